sll_iter_unit: RTL

Iterative logical-left-shift unit for the processor's ALU shift path. It is the left-direction counterpart to the fixed arithmetic-right-shift stages. It applies a variable 0–31 bit left shift over five clock cycles, one binary-weighted stage per cycle (16, 8, 4, 2, 1). This replaces a wide combinational barrel shifter. A start/ready/done handshake connects it to the execute-stage stall logic.

---
 rtl/alu_shift_pkg.sv | 18 +
 rtl/sll_iter_unit_if.sv | 25 ++
 rtl/shl_stage.sv | 18 +
 rtl/sll_iter_unit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// Shared constants and FSM state encoding for the ALU shift-path units.
// Contents: WIDTH/SHW data and shift-amount widths, state_t encoding, first stage index.
// No ports; imported by the interface, the stage and the top level.
package alu_shift_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Stage index of the widest (16-bit) shift, applied first.
    localparam logic [2:0] K_FIRST = 3'd4;

endpackage

// File: rtl/sll_iter_unit_if.sv
// Request/response bundle between the execute stage and the iterative shifter.
// master: drives start, data_in, shamt; observes ready, done, result, lost.
// slave: the shifter side, with the opposite directions.
interface sll_iter_unit_if;
    import alu_shift_pkg::*;

    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shamt;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             lost;

    modport master (
        output start, data_in, shamt,
        input  ready, done, result, lost
    );

    modport slave (
        input  start, data_in, shamt,
        output ready, done, result, lost
    );

endinterface

// File: rtl/shl_stage.sv
// One binary-weighted left-shift stage, purely combinational, zero latency.
// Ports: en (apply the shift), in (operand) -> out (shifted or passed through),
//        spill (a 1 bit would leave the top of the word); no backpressure.
module shl_stage
    import alu_shift_pkg::*;
#(
    parameter int AMT = 1
) (
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             spill
);

    assign out   = en ? (in << AMT) : in;
    assign spill = en & (|in[WIDTH-1:WIDTH-AMT]);

endmodule

// File: rtl/sll_iter_unit.sv
// Iterative 32-bit logical left shift, one weighted stage (16,8,4,2,1) per cycle.
// Latency 5 cycles from the accepting edge to done; ready is low while shifting,
// start is ignored then. Ports: clock, reset (sync, active low), bus (slave side).
module sll_iter_unit
    import alu_shift_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    sll_iter_unit_if.slave    bus
);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   amt;
    logic [2:0]       k;
    logic             lost_acc;

    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             lost_q;

    logic [WIDTH-1:0] stage_out [SHW];
    logic [SHW-1:0]   stage_spill;
    logic [WIDTH-1:0] sel_out;
    logic             sel_spill;

    // All stages look at the current work word; each is enabled by its own
    // shift-amount bit, and k picks which one is committed this cycle.
    for (genvar i = 0; i < SHW; i++) begin : g_stage
        shl_stage #(
            .AMT (1 << i)
        ) u_stage (
            .en    (amt[i]),
            .in    (work),
            .out   (stage_out[i]),
            .spill (stage_spill[i])
        );
    end

    always_comb begin
        sel_out   = work;
        sel_spill = 1'b0;
        case (k)
            3'd0: begin sel_out = stage_out[0]; sel_spill = stage_spill[0]; end
            3'd1: begin sel_out = stage_out[1]; sel_spill = stage_spill[1]; end
            3'd2: begin sel_out = stage_out[2]; sel_spill = stage_spill[2]; end
            3'd3: begin sel_out = stage_out[3]; sel_spill = stage_spill[3]; end
            3'd4: begin sel_out = stage_out[4]; sel_spill = stage_spill[4]; end
            default: begin sel_out = work; sel_spill = 1'b0; end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            work     <= '0;
            amt      <= '0;
            k        <= K_FIRST;
            lost_acc <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            lost_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        work     <= bus.data_in;
                        amt      <= bus.shamt;
                        lost_acc <= 1'b0;
                        k        <= K_FIRST;
                        ready_q  <= 1'b0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work     <= sel_out;
                    lost_acc <= lost_acc | sel_spill;
                    if (k == 3'd0) begin
                        // Last stage: publish the result straight from the
                        // stage output so it is visible in the DONE cycle.
                        result_q <= sel_out;
                        lost_q   <= lost_acc | sel_spill;
                        ready_q  <= 1'b1;
                        done_q   <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        k <= k - 3'd1;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        work     <= bus.data_in;
                        amt      <= bus.shamt;
                        lost_acc <= 1'b0;
                        k        <= K_FIRST;
                        ready_q  <= 1'b0;
                        state    <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.lost   = lost_q;

endmodule
